// File: rtl/credit_sink_port.sv
// Router-side ingress endpoint of the credit-based flit link: per-VC FIFOs, round-robin egress, credit return.
// Optional CREDIT_SINK_STATS_EN adds flit-in/flit-out/stall counters.
module credit_sink_port #(
  parameter int DEPTH      = 8,
  parameter int VC_BITS    = 2,
  parameter int NUM_VCS    = 2,
  parameter int FLIT_WIDTH = 261,
  parameter int VC_LSB     = 256
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [FLIT_WIDTH-1:0] putFlit_flit_in,
  input  logic                  EN_putFlit,
  output logic [VC_BITS:0]      getCredits,
  input  logic                  EN_getCredits,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic [VC_BITS-1:0]    out_vc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow_err
`ifdef CREDIT_SINK_STATS_EN
  ,
  output logic [31:0]           stat_flits_in,
  output logic [31:0]           stat_flits_out,
  output logic [31:0]           stat_stall_cycles
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [FLIT_WIDTH-1:0] mem [NUM_VCS][DEPTH];
  logic [PTR_W-1:0]      enq_ptr [NUM_VCS];
  logic [PTR_W-1:0]      deq_ptr [NUM_VCS];
  logic [CNT_W-1:0]      pend    [NUM_VCS];
  logic [NUM_VCS-1:0]    maybe_full, empty, full, enq, deq, crd_dec, crd_sat;
  logic [VC_BITS-1:0]    rr_ptr, rr_vc, grant_vc, hold_vc, in_vc, crd_vc;
  logic                  rr_found, hold, fire, in_try, in_drop, crd_valid, crd_take;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Matching pointers mean full or empty; maybe_full tells them apart.
  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      empty[v] = (enq_ptr[v] == deq_ptr[v]) && !maybe_full[v];
      full[v]  = (enq_ptr[v] == deq_ptr[v]) &&  maybe_full[v];
    end
  end

  // The grant is frozen while a stalled flit is presented so out_* cannot shift under the consumer.
  always_comb begin
    rr_vc    = rr_ptr;
    rr_found = 1'b0;
    for (int i = 0; i < NUM_VCS; i++) begin
      if (!rr_found && !empty[(int'(rr_ptr) + i) % NUM_VCS]) begin
        rr_found = 1'b1;
        rr_vc    = VC_BITS'((int'(rr_ptr) + i) % NUM_VCS);
      end
    end
    grant_vc  = hold ? hold_vc : rr_vc;
    out_valid = ~&empty;
    fire      = out_valid && out_ready;
    out_vc    = out_valid ? grant_vc : '0;
    out_flit  = out_valid ? mem[grant_vc][deq_ptr[grant_vc]] : '0;
  end

  // A full FIFO still accepts when its head leaves on the same edge.
  always_comb begin
    in_vc  = putFlit_flit_in[VC_LSB +: VC_BITS];
    in_try = EN_putFlit && putFlit_flit_in[FLIT_WIDTH-1];
    for (int v = 0; v < NUM_VCS; v++) begin
      deq[v] = fire && (grant_vc == VC_BITS'(v));
      enq[v] = in_try && (in_vc == VC_BITS'(v)) && (!full[v] || deq[v]);
    end
    in_drop = in_try && ~|enq;
  end

  // Credits go out lowest-VC-first from the registered pending counters.
  always_comb begin
    crd_valid = 1'b0;
    crd_vc    = '0;
    for (int v = NUM_VCS - 1; v >= 0; v--) begin
      if (pend[v] != '0) begin
        crd_valid = 1'b1;
        crd_vc    = VC_BITS'(v);
      end
    end
    getCredits = crd_valid ? {1'b1, crd_vc} : '0;
    crd_take   = EN_getCredits && crd_valid;
    for (int v = 0; v < NUM_VCS; v++) begin
      crd_dec[v] = crd_take && (crd_vc == VC_BITS'(v));
      crd_sat[v] = deq[v] && !crd_dec[v] && (pend[v] == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge CLK) begin
    for (int v = 0; v < NUM_VCS; v++) begin
      if (enq[v]) mem[v][enq_ptr[v]] <= putFlit_flit_in;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        enq_ptr[v] <= '0;
        deq_ptr[v] <= '0;
        pend[v]    <= '0;
      end
      maybe_full   <= '0;
      rr_ptr       <= '0;
      hold         <= 1'b0;
      hold_vc      <= '0;
      overflow_err <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (enq[v]) enq_ptr[v] <= ptr_inc(enq_ptr[v]);
        if (deq[v]) deq_ptr[v] <= ptr_inc(deq_ptr[v]);
        if (enq[v] != deq[v]) maybe_full[v] <= enq[v];
        if (deq[v] && !crd_dec[v] && !crd_sat[v]) pend[v] <= pend[v] + CNT_W'(1);
        else if (crd_dec[v] && !deq[v])           pend[v] <= pend[v] - CNT_W'(1);
      end
      hold    <= out_valid && !out_ready;
      hold_vc <= grant_vc;
      if (fire) rr_ptr <= (grant_vc == VC_BITS'(NUM_VCS - 1)) ? '0 : grant_vc + VC_BITS'(1);
      if (in_drop || |crd_sat) overflow_err <= 1'b1;
    end
  end

`ifdef CREDIT_SINK_STATS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_flits_in     <= '0;
      stat_flits_out    <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (|enq) stat_flits_in <= stat_flits_in + 32'd1;
      if (fire) stat_flits_out <= stat_flits_out + 32'd1;
      if (out_valid && !out_ready) stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_credit_sink_port.sv
// Directed bench for credit_sink_port: per-VC scoreboard queues checked on every fire, plus credit/error checks.
module tb_credit_sink_port;

  typedef logic [260:0] flit_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  flit_t      putFlit_flit_in = '0;
  logic       EN_putFlit = 1'b0;
  logic       EN_getCredits = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] getCredits;
  flit_t      out_flit;
  logic [1:0] out_vc;
  logic       out_valid;
  logic       overflow_err;
`ifdef CREDIT_SINK_STATS_EN
  logic [31:0] stat_flits_in, stat_flits_out, stat_stall_cycles;
`endif

  int    checks = 0;
  int    errors = 0;
  flit_t exp_q [2][$];
  int    ord_q [$];
  flit_t first_flit;

  credit_sink_port dut (
    .CLK(CLK), .RST(RST),
    .putFlit_flit_in(putFlit_flit_in), .EN_putFlit(EN_putFlit),
    .getCredits(getCredits), .EN_getCredits(EN_getCredits),
    .out_flit(out_flit), .out_vc(out_vc), .out_valid(out_valid),
    .out_ready(out_ready), .overflow_err(overflow_err)
`ifdef CREDIT_SINK_STATS_EN
    , .stat_flits_in(stat_flits_in), .stat_flits_out(stat_flits_out),
    .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input flit_t obs, input flit_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic flit_t mkFlit(input logic [1:0] vc, input logic [31:0] payload);
    flit_t f;
    f = '0;
    f[260] = 1'b1;
    f[257:256] = vc;
    f[31:0] = payload;
    f[255:224] = ~payload;
    return f;
  endfunction

  task automatic tick();
    @(negedge CLK);
  endtask

  // Drives one flit for one cycle; expected-accepted flits go to the scoreboard.
  task automatic applyStimulus(input logic [1:0] vc, input logic [31:0] payload, input bit accept);
    flit_t f;
    f = mkFlit(vc, payload);
    if (accept) exp_q[vc].push_back(f);
    putFlit_flit_in = f;
    EN_putFlit = 1'b1;
    tick();
    EN_putFlit = 1'b0;
  endtask

  task automatic resetDut();
    RST = 1'b1;
    EN_putFlit = 1'b0;
    out_ready = 1'b0;
    repeat (2) tick();
    RST = 1'b0;
    exp_q[0].delete();
    exp_q[1].delete();
    ord_q.delete();
  endtask

  task automatic waitDrain(input int max_cycles);
    int n = 0;
    while ((exp_q[0].size() + exp_q[1].size()) != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    checkOutput("drain_left", flit_t'(exp_q[0].size() + exp_q[1].size()), '0);
  endtask

  // Scoreboard side: every fire must match the head of that VC's expected queue.
  always @(negedge CLK) begin
    #2;
    if (!RST && out_valid && out_ready) begin
      if (ord_q.size() > 0) checkOutput("rr_order", flit_t'(out_vc), flit_t'(ord_q.pop_front()));
      if (out_vc < 2'd2 && exp_q[out_vc].size() > 0)
        checkOutput("fire_data", out_flit, exp_q[out_vc].pop_front());
      else
        checkOutput("unexpected_fire", flit_t'(out_valid), '0);
    end
  end

  initial begin
    resetDut();
    checkOutput("rst_out_valid", flit_t'(out_valid), '0);
    checkOutput("rst_out_flit", out_flit, '0);
    checkOutput("rst_out_vc", flit_t'(out_vc), '0);
    checkOutput("rst_credits", flit_t'(getCredits), '0);
    checkOutput("rst_err", flit_t'(overflow_err), '0);

    // Single flit on VC1
    out_ready = 1'b1;
    EN_getCredits = 1'b1;
    applyStimulus(2'd1, 32'h0000_0101, 1'b1);
    checkOutput("t1_valid", flit_t'(out_valid), 1);
    checkOutput("t1_vc", flit_t'(out_vc), 1);
    tick();
    checkOutput("t1_credit", flit_t'(getCredits), 3'b101);
    tick();
    checkOutput("t1_credit_done", flit_t'(getCredits), '0);
    checkOutput("t1_empty", flit_t'(out_valid), '0);
`ifdef CREDIT_SINK_STATS_EN
    checkOutput("stat_in", flit_t'(stat_flits_in), 1);
    checkOutput("stat_out", flit_t'(stat_flits_out), 1);
    checkOutput("stat_stall", flit_t'(stat_stall_cycles), 0);
`endif

    // Fill VC0, then overflow it
    out_ready = 1'b0;
    first_flit = mkFlit(2'd0, 32'h200);
    for (int i = 0; i < 8; i++) applyStimulus(2'd0, 32'h200 + i, 1'b1);
    checkOutput("t2_no_err", flit_t'(overflow_err), '0);
    applyStimulus(2'd0, 32'h2FF, 1'b0);
    checkOutput("t2_err", flit_t'(overflow_err), 1);
    checkOutput("t2_head", out_flit, first_flit);
    checkOutput("t2_head_vc", flit_t'(out_vc), '0);
    out_ready = 1'b1;
    waitDrain(30);
    checkOutput("t2_err_sticky", flit_t'(overflow_err), 1);

    // Round-robin with a 2-cycle stall
    resetDut();
    EN_getCredits = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'd0, 32'h300 + i, 1'b1);
      applyStimulus(2'd1, 32'h310 + i, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      ord_q.push_back(0);
      ord_q.push_back(1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checkOutput("t3_stall_vc", flit_t'(out_vc), 1);
      checkOutput("t3_stall_flit", out_flit, mkFlit(2'd1, 32'h310));
      tick();
    end
    out_ready = 1'b1;
    waitDrain(30);
    checkOutput("t3_order_left", flit_t'(ord_q.size()), '0);
    repeat (8) tick();
    checkOutput("t3_credits_idle", flit_t'(getCredits), '0);

    // Withheld credits accumulate, then return one per cycle
    EN_getCredits = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(2'd0, 32'h400 + i, 1'b1);
    waitDrain(30);
    tick();
    EN_getCredits = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("t4_credit", flit_t'(getCredits), 3'b100);
      tick();
    end
    checkOutput("t4_credit_end", flit_t'(getCredits), '0);

    // Full FIFO with simultaneous enq and fire
    resetDut();
    EN_getCredits = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(2'd0, 32'h500 + i, 1'b1);
    out_ready = 1'b1;
    applyStimulus(2'd0, 32'h508, 1'b1);
    out_ready = 1'b0;
    checkOutput("t5_no_err", flit_t'(overflow_err), '0);
    applyStimulus(2'd0, 32'h5FF, 1'b0);
    checkOutput("t5_still_full", flit_t'(overflow_err), 1);
    out_ready = 1'b1;
    waitDrain(30);
    tick();
    checkOutput("t5_empty", flit_t'(out_valid), '0);

    // Asynchronous reset mid-burst
    resetDut();
    EN_getCredits = 1'b0;
    out_ready = 1'b1;
    applyStimulus(2'd0, 32'h600, 1'b1);
    tick();
    out_ready = 1'b0;
    applyStimulus(2'd0, 32'h601, 1'b1);
    applyStimulus(2'd0, 32'h602, 1'b1);
    applyStimulus(2'd3, 32'h6FF, 1'b0);
    checkOutput("t6_pre_valid", flit_t'(out_valid), 1);
    checkOutput("t6_pre_credit", flit_t'(getCredits), 3'b100);
    checkOutput("t6_pre_err", flit_t'(overflow_err), 1);
    #3;
    RST = 1'b1;
    #1;
    checkOutput("t6_async_valid", flit_t'(out_valid), '0);
    checkOutput("t6_async_credit", flit_t'(getCredits), '0);
    checkOutput("t6_async_err", flit_t'(overflow_err), '0);
    resetDut();
    tick();
    checkOutput("t6_post_valid", flit_t'(out_valid), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
